// File: rtl/maxpool2x2.sv
// maxpool2x2: 2x2 stride-2 max-pooling of a raster-ordered, multi-channel
// signed feature stream. Each channel is pooled independently and in parallel.
// Even columns are held, odd columns produce a horizontal max; on even rows the
// horizontal max is parked in a half-width row buffer, and on odd rows it is
// combined with the parked value to form the pooled output one cycle later.
// Optional feature: define POOL_RELU_EN to clamp negative pooled values to zero.
module maxpool2x2 #(
  parameter int NUM_FILTERS   = 6,
  parameter int FEATURE_WIDTH = 16,
  parameter int IN_WIDTH      = 28,
  parameter int IN_HEIGHT     = 28
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_feature_valid,
  input  logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]   i_features,
  output logic                                        o_feature_valid,
  output logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]   o_features,
  output logic                                        o_frame_done
);

  localparam int COL_W  = (IN_WIDTH  > 2) ? $clog2(IN_WIDTH)  : 1;
  localparam int ROW_W  = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int HALF_W = IN_WIDTH / 2;
  localparam int BUF_AW = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  typedef logic [FEATURE_WIDTH-1:0]                   feat_t;
  typedef logic [NUM_FILTERS-1:0][FEATURE_WIDTH-1:0]  beat_t;

  // Odd dimensions would leave a partial window that can never be emitted.
  if ((IN_WIDTH % 2) != 0) begin : g_bad_width
    $error("maxpool2x2: IN_WIDTH must be even");
  end
  if ((IN_HEIGHT % 2) != 0) begin : g_bad_height
    $error("maxpool2x2: IN_HEIGHT must be even");
  end

  // Signed two's-complement maximum; ties return the (equal) first operand.
  function automatic feat_t smax(input feat_t a, input feat_t b);
    if ($signed(a) >= $signed(b)) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  logic [COL_W-1:0]  col_cnt_r;
  logic [ROW_W-1:0]  row_cnt_r;
  beat_t             hold_r;
  beat_t             rowbuf_r [HALF_W];

  logic [BUF_AW-1:0] buf_idx_s;
  logic              col_last_s;
  logic              row_last_s;
  logic              accept_odd_s;
  logic              out_fire_s;
  beat_t             hmax_s;
  beat_t             vmax_s;
  beat_t             pooled_s;

  assign buf_idx_s    = BUF_AW'(col_cnt_r >> 1);
  assign col_last_s   = (col_cnt_r == COL_W'(IN_WIDTH - 1));
  assign row_last_s   = (row_cnt_r == ROW_W'(IN_HEIGHT - 1));
  assign accept_odd_s = i_feature_valid & col_cnt_r[0];
  assign out_fire_s   = accept_odd_s & row_cnt_r[0];

  // Per-channel horizontal max, vertical max against the row buffer, optional ReLU.
  always_comb begin
    hmax_s   = '0;
    vmax_s   = '0;
    pooled_s = '0;
    for (int c = 0; c < NUM_FILTERS; c++) begin
      hmax_s[c] = smax(hold_r[c], i_features[c]);
      vmax_s[c] = smax(rowbuf_r[buf_idx_s][c], hmax_s[c]);
`ifdef POOL_RELU_EN
      if (vmax_s[c][FEATURE_WIDTH-1]) begin
        pooled_s[c] = '0;
      end else begin
        pooled_s[c] = vmax_s[c];
      end
`else
      pooled_s[c] = vmax_s[c];
`endif
    end
  end

  // Raster position counters; advance only on accepted beats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_cnt_r <= '0;
      row_cnt_r <= '0;
    end else if (i_feature_valid) begin
      if (col_last_s) begin
        col_cnt_r <= '0;
        if (row_last_s) begin
          row_cnt_r <= '0;
        end else begin
          row_cnt_r <= row_cnt_r + ROW_W'(1);
        end
      end else begin
        col_cnt_r <= col_cnt_r + COL_W'(1);
      end
    end
  end

  // Column hold and row buffer; always written before read, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (i_feature_valid && !col_cnt_r[0]) begin
      hold_r <= i_features;
    end
    if (accept_odd_s && !row_cnt_r[0]) begin
      rowbuf_r[buf_idx_s] <= hmax_s;
    end
  end

  // Registered pooled output; data holds between pulses, valid/done are 1-cycle pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_feature_valid <= 1'b0;
      o_frame_done    <= 1'b0;
      o_features      <= '0;
    end else begin
      o_feature_valid <= out_fire_s;
      o_frame_done    <= out_fire_s & row_last_s & col_last_s;
      if (out_fire_s) begin
        o_features <= pooled_s;
      end
    end
  end

endmodule
